// File: rtl/vga_plot_pkg.sv
// Shared constants and FSM encoding for the VGA rectangle plotter.
// Screen size, coordinate widths and the plotter state type live here.
package vga_plot_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int C_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vga_xy_stepper.sv
// Pixel walker: holds the current x/y position and the rectangle bounds.
// It steps row-major, skips interior columns in outline mode and flags the final pixel.
module vga_xy_stepper
    import vga_plot_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] load_x0,
    input  logic [X_W-1:0] load_x_end,
    input  logic [Y_W-1:0] load_y0,
    input  logic [Y_W-1:0] load_y_end,
    input  logic           load_outline,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x0;
    logic [X_W-1:0] x_end;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y_end;
    logic           outline;
    logic           interior_row;

    assign interior_row = outline && (y != y0) && (y != y_end);
    assign last         = (x == x_end) && (y == y_end);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            x0      <= '0;
            x_end   <= '0;
            y0      <= '0;
            y_end   <= '0;
            outline <= 1'b0;
        end else if (load) begin
            x       <= load_x0;
            y       <= load_y0;
            x0      <= load_x0;
            x_end   <= load_x_end;
            y0      <= load_y0;
            y_end   <= load_y_end;
            outline <= load_outline;
        end else if (advance) begin
            if (x == x_end) begin
                x <= x0;
                y <= y + Y_W'(1);
            end else if (interior_row && (x == x0)) begin
                // Interior outline rows only touch the two side columns.
                x <= x_end;
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_rect_plotter.sv
// Rectangle drawer feeding the DESim VGA pixel port: handshake, clipping,
// control FSM and the registered pixel-write stream.
module vga_rect_plotter
    import vga_plot_pkg::*;
#(
    parameter int H_RES = vga_plot_pkg::H_RES,
    parameter int V_RES = vga_plot_pkg::V_RES
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_y,
    input  logic [X_W-1:0] req_w,
    input  logic [Y_W-1:0] req_h,
    input  logic [C_W-1:0] req_color,
    input  logic           req_outline,
    output logic [X_W-1:0] VGA_X,
    output logic [Y_W-1:0] VGA_Y,
    output logic [C_W-1:0] VGA_COLOR,
    output logic           plot,
    output logic           done
);

    state_t state, next_state;

    logic        load;
    logic        advance;
    logic        last;
    logic        empty;
    logic [10:0] x_room;
    logic [10:0] y_room;
    logic [10:0] w_eff;
    logic [10:0] h_eff;
    logic [X_W-1:0] x_end;
    logic [Y_W-1:0] y_end;

    // Clip against the visible area in 11 bits so H_RES - x0 cannot overflow.
    assign x_room = 11'(H_RES) - {1'b0, req_x};
    assign y_room = 11'(V_RES) - {2'b0, req_y};
    assign empty  = (req_w == '0) || (req_h == '0) ||
                    ({1'b0, req_x} >= 11'(H_RES)) || ({2'b0, req_y} >= 11'(V_RES));
    assign w_eff  = ({1'b0, req_w} < x_room) ? {1'b0, req_w} : x_room;
    assign h_eff  = ({2'b0, req_h} < y_room) ? {2'b0, req_h} : y_room;
    assign x_end  = X_W'({1'b0, req_x} + w_eff - 11'd1);
    assign y_end  = Y_W'({2'b0, req_y} + h_eff - 11'd1);

    assign req_ready = (state == ST_IDLE);

    vga_xy_stepper u_stepper (
        .clk          (CLOCK_50),
        .reset        (reset),
        .load         (load),
        .advance      (advance),
        .load_x0      (req_x),
        .load_x_end   (x_end),
        .load_y0      (req_y),
        .load_y_end   (y_end),
        .load_outline (req_outline),
        .x            (VGA_X),
        .y            (VGA_Y),
        .last         (last)
    );

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state = empty ? ST_DONE : ST_DRAW;
                    load       = !empty;
                end
            end
            ST_DRAW: begin
                if (last) next_state = ST_DONE;
                else      advance    = 1'b1;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The stepper position is the pixel being shown, so plot simply mirrors DRAW.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            plot      <= 1'b0;
            done      <= 1'b0;
            VGA_COLOR <= '0;
        end else begin
            state <= next_state;
            plot  <= (next_state == ST_DRAW);
            done  <= (next_state == ST_DONE);
            if (load) VGA_COLOR <= req_color;
        end
    end

endmodule
